filterbank_mac_sequencer: RTL

//  Time-multiplexes one external MAC, coefficient ROM and sample-history RAM across NUM_BANDS FIR bands.

---
 rtl/filterbank_mac_sequencer_if.sv | 48 ++++
 rtl/filterbank_mac_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/filterbank_mac_sequencer_if.sv
// Sequencer bus bundle: decimator strobe, history RAM, coefficient ROM, MAC and band outputs.
// sat_flag exists only when FBANK_SAT_EN is defined.
interface filterbank_mac_sequencer_if #(
  parameter int HAW   = 5,
  parameter int CAW   = 8,
  parameter int ACC_W = 24,
  parameter int OUT_W = 8
);
  logic             sample_ready;
  logic [7:0]       sample_in;
  logic             hist_we;
  logic [HAW-1:0]   hist_waddr;
  logic [7:0]       hist_wdata;
  logic [HAW-1:0]   hist_raddr;
  logic [CAW-1:0]   coef_addr;
  logic             mac_en;
  logic             mac_clr;
  logic [ACC_W-1:0] mac_result;
  logic             band_valid;
  logic [2:0]       band_idx;
  logic [OUT_W-1:0] band_data;
  logic             frame_done;
  logic             busy;
  logic             overrun;
`ifdef FBANK_SAT_EN
  logic             sat_flag;
`endif

  modport master (
    input  sample_ready, sample_in, mac_result,
`ifdef FBANK_SAT_EN
    output sat_flag,
`endif
    output hist_we, hist_waddr, hist_wdata, hist_raddr, coef_addr,
    output mac_en, mac_clr, band_valid, band_idx, band_data,
    output frame_done, busy, overrun
  );

  modport slave (
    output sample_ready, sample_in, mac_result,
`ifdef FBANK_SAT_EN
    input  sat_flag,
`endif
    input  hist_we, hist_waddr, hist_wdata, hist_raddr, coef_addr,
    input  mac_en, mac_clr, band_valid, band_idx, band_data,
    input  frame_done, busy, overrun
  );
endinterface

// File: rtl/filterbank_mac_sequencer.sv
// Shares one MAC, coefficient ROM and history RAM across NUM_BANDS FIR bands, one frame per sample.
// Optional FBANK_SAT_EN: clamp band outputs instead of truncating, and drive sat_flag.
module filterbank_mac_sequencer #(
  parameter int NUM_BANDS = 5,
  parameter int NUM_TAPS  = 31,
  parameter int HAW       = 5,
  parameter int CAW       = 8,
  parameter int ACC_W     = 24,
  parameter int SHIFT     = 10,
  parameter int OUT_W     = 8,
  parameter int MAC_LAT   = 1
) (
  input logic                         clk,
  input logic                         reset,
  filterbank_mac_sequencer_if.master  bus
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE} state_t;
  localparam int WW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  state_t           state_q, state_d;
  logic [HAW-1:0]   tap_q, tap_d;
  logic [2:0]       band_q, band_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [HAW-1:0]   wptr_q, wptr_d;
  logic [HAW-1:0]   newest_q, newest_d;
  logic             load_addr_s;
  logic             hist_we_q, hist_we_d;
  logic [HAW-1:0]   hist_waddr_q, hist_waddr_d;
  logic [7:0]       hist_wdata_q, hist_wdata_d;
  logic [HAW-1:0]   hist_raddr_q, hist_raddr_d;
  logic [CAW-1:0]   coef_addr_q, coef_addr_d;
  logic             mac_en_q, mac_en_d;
  logic             mac_clr_q, mac_clr_d;
  logic             band_valid_q, band_valid_d;
  logic [2:0]       band_idx_q, band_idx_d;
  logic [OUT_W-1:0] band_data_q, band_data_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

`ifdef FBANK_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
  logic sat_flag_q, sat_flag_d;

  // Returns {clamped, value} for the shifted accumulator.
  function automatic logic [OUT_W:0] sat_scale(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> SHIFT;
    if (sh > SAT_MAX) begin
      return {1'b1, SAT_MAX[OUT_W-1:0]};
    end else if (sh < SAT_MIN) begin
      return {1'b1, SAT_MIN[OUT_W-1:0]};
    end else begin
      return {1'b0, sh[OUT_W-1:0]};
    end
  endfunction
`endif

  // Next-state and next-output computation for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    band_d       = band_q;
    wait_d       = wait_q;
    wptr_d       = wptr_q;
    newest_d     = newest_q;
    load_addr_s  = 1'b0;
    hist_we_d    = 1'b0;
    hist_waddr_d = hist_waddr_q;
    hist_wdata_d = hist_wdata_q;
    hist_raddr_d = hist_raddr_q;
    coef_addr_d  = coef_addr_q;
    // ROM/RAM read data lags the address by a cycle, so the MAC enable follows the issue cycle.
    mac_en_d     = (state_q == S_ISSUE);
    mac_clr_d    = (state_q == S_ISSUE) && (tap_q == HAW'(0));
    band_valid_d = 1'b0;
    band_idx_d   = band_idx_q;
    band_data_d  = band_data_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q | (bus.sample_ready && (state_q != S_IDLE));
`ifdef FBANK_SAT_EN
    sat_flag_d   = sat_flag_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.sample_ready) begin
          state_d      = S_WRITE;
          hist_we_d    = 1'b1;
          hist_waddr_d = wptr_q;
          hist_wdata_d = bus.sample_in;
          newest_d     = wptr_q;
          wptr_d       = wptr_q + HAW'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        state_d     = S_ISSUE;
        tap_d       = HAW'(0);
        band_d      = 3'd0;
        load_addr_s = 1'b1;
      end
      S_ISSUE: begin
        if (tap_q == HAW'(NUM_TAPS - 1)) begin
          state_d = S_WAIT;
          wait_d  = WW'(MAC_LAT - 1);
        end else begin
          tap_d       = tap_q + HAW'(1);
          load_addr_s = 1'b1;
        end
      end
      S_WAIT: begin
        if (wait_q == WW'(0)) begin
          state_d      = S_CAPTURE;
          band_valid_d = 1'b1;
          band_idx_d   = band_q;
`ifdef FBANK_SAT_EN
          {sat_flag_d, band_data_d} = sat_scale(bus.mac_result);
`else
          band_data_d  = OUT_W'($signed(bus.mac_result) >>> SHIFT);
`endif
        end else begin
          wait_d = wait_q - WW'(1);
        end
      end
      S_CAPTURE: begin
        if (band_q == 3'(NUM_BANDS - 1)) begin
          state_d      = S_DONE;
          frame_done_d = 1'b1;
        end else begin
          state_d     = S_ISSUE;
          band_d      = band_q + 3'd1;
          tap_d       = HAW'(0);
          load_addr_s = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_addr_s) begin
      hist_raddr_d = newest_d - tap_d;
      coef_addr_d  = CAW'(32'(band_d) * NUM_TAPS + 32'(tap_d));
    end else begin
      hist_raddr_d = hist_raddr_q;
      coef_addr_d  = coef_addr_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, pointer and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tap_q        <= HAW'(0);
      band_q       <= 3'd0;
      wait_q       <= WW'(0);
      wptr_q       <= HAW'(0);
      newest_q     <= HAW'(0);
      hist_we_q    <= 1'b0;
      hist_waddr_q <= HAW'(0);
      hist_wdata_q <= 8'd0;
      hist_raddr_q <= HAW'(0);
      coef_addr_q  <= CAW'(0);
      mac_en_q     <= 1'b0;
      mac_clr_q    <= 1'b0;
      band_valid_q <= 1'b0;
      band_idx_q   <= 3'd0;
      band_data_q  <= OUT_W'(0);
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef FBANK_SAT_EN
      sat_flag_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      band_q       <= band_d;
      wait_q       <= wait_d;
      wptr_q       <= wptr_d;
      newest_q     <= newest_d;
      hist_we_q    <= hist_we_d;
      hist_waddr_q <= hist_waddr_d;
      hist_wdata_q <= hist_wdata_d;
      hist_raddr_q <= hist_raddr_d;
      coef_addr_q  <= coef_addr_d;
      mac_en_q     <= mac_en_d;
      mac_clr_q    <= mac_clr_d;
      band_valid_q <= band_valid_d;
      band_idx_q   <= band_idx_d;
      band_data_q  <= band_data_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
`ifdef FBANK_SAT_EN
      sat_flag_q   <= sat_flag_d;
`endif
    end
  end

  assign bus.hist_we    = hist_we_q;
  assign bus.hist_waddr = hist_waddr_q;
  assign bus.hist_wdata = hist_wdata_q;
  assign bus.hist_raddr = hist_raddr_q;
  assign bus.coef_addr  = coef_addr_q;
  assign bus.mac_en     = mac_en_q;
  assign bus.mac_clr    = mac_clr_q;
  assign bus.band_valid = band_valid_q;
  assign bus.band_idx   = band_idx_q;
  assign bus.band_data  = band_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;
`ifdef FBANK_SAT_EN
  assign bus.sat_flag   = sat_flag_q;
`endif

endmodule
